// File: rtl/action_sequencer_if.sv
// Command bus from the ALU into the action sequencer: a 16-bit action code
// qualified by a single valid strobe, sampled on every rising clock edge.
interface action_sequencer_if;
    logic [15:0] act_code;
    logic        act_valid;

    modport master (output act_code, output act_valid);
    modport slave  (input  act_code, input  act_valid);
endinterface

// File: rtl/action_sequencer.sv
// Action sequencer: turns ALU action codes into timed motor/steer/brake drive
// commands. Turns and brakes hold for a minimum number of cycles, DRIVE is
// guarded by a watchdog, and unknown codes are counted as faults.
module action_sequencer #(
    parameter int          TURN_CYCLES  = 8,
    parameter int          BRAKE_CYCLES = 4,
    parameter int          WDOG_CYCLES  = 64,
    parameter logic [15:0] ACT_STOP     = 16'h0001,
    parameter logic [15:0] ACT_CONTINUE = 16'h0002,
    parameter logic [15:0] ACT_LEFT     = 16'h0003,
    parameter logic [15:0] ACT_RIGHT    = 16'h0004
) (
    input  logic                       clk,
    input  logic                       rst,
    action_sequencer_if.slave          act,
    output logic                       motor_en,
    output logic                       steer_left,
    output logic                       steer_right,
    output logic                       brake,
    output logic                       busy,
    output logic [2:0]                 state_o,
    output logic [7:0]                 fault_cnt,
    output logic                       wdog_trip
);
    // Turn and brake share one timer, so it is sized for the longer of the two.
    localparam int TMAX = (TURN_CYCLES > BRAKE_CYCLES) ? TURN_CYCLES : BRAKE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int WW   = $clog2(WDOG_CYCLES + 1);

    localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] BRAKE_LOAD = TW'(BRAKE_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_LOAD  = WW'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        TURN_L = 3'd2,
        TURN_R = 3'd3,
        BRAKE  = 3'd4
    } state_t;

    // What to do when the current turn expires.
    typedef enum logic [1:0] {
        P_NONE  = 2'd0,
        P_DRIVE = 2'd1,
        P_LEFT  = 2'd2,
        P_RIGHT = 2'd3
    } pend_t;

    state_t        state_q, state_d;
    pend_t         pend_q, pend_d, pend_nx;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          trip_d;

    logic is_stop, is_cont, is_left, is_right, is_bad;

    assign is_stop  = act.act_valid && (act.act_code == ACT_STOP);
    assign is_cont  = act.act_valid && (act.act_code == ACT_CONTINUE);
    assign is_left  = act.act_valid && (act.act_code == ACT_LEFT);
    assign is_right = act.act_valid && (act.act_code == ACT_RIGHT);
    // Code 0 is a silent NOP; anything else unrecognised is a fault.
    assign is_bad   = act.act_valid && (act.act_code != 16'h0000) &&
                      !(is_stop || is_cont || is_left || is_right);

    // State, timers, pending command and watchdog pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= P_NONE;
            tmr_q     <= '0;
            wdog_q    <= '0;
            wdog_trip <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            tmr_q     <= tmr_d;
            wdog_q    <= wdog_d;
            wdog_trip <= trip_d;
        end
    end

    // Next-state logic; STOP always wins, then watchdog, then timer/pending.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        pend_nx = pend_q;
        tmr_d   = tmr_q;
        wdog_d  = wdog_q;
        trip_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_cont) begin
                    state_d = DRIVE;
                    wdog_d  = WDOG_LOAD;
                end else if (is_left) begin
                    state_d = TURN_L;
                    tmr_d   = TURN_LOAD;
                end else if (is_right) begin
                    state_d = TURN_R;
                    tmr_d   = TURN_LOAD;
                end
            end
            DRIVE: begin
                if (is_stop) begin
                    state_d = BRAKE;
                    tmr_d   = BRAKE_LOAD;
                end else if (is_left) begin
                    state_d = TURN_L;
                    tmr_d   = TURN_LOAD;
                end else if (is_right) begin
                    state_d = TURN_R;
                    tmr_d   = TURN_LOAD;
                end else if (is_cont) begin
                    wdog_d  = WDOG_LOAD;
                end else if (wdog_q == '0) begin
                    state_d = BRAKE;
                    tmr_d   = BRAKE_LOAD;
                    trip_d  = 1'b1;
                end else begin
                    wdog_d  = wdog_q - 1'b1;
                end
            end
            TURN_L, TURN_R: begin
                if (is_stop) begin
                    state_d = BRAKE;
                    tmr_d   = BRAKE_LOAD;
                    pend_d  = P_NONE;
                end else begin
                    // A command on the expiry cycle is consumed at that same edge.
                    if (is_left)       pend_nx = P_LEFT;
                    else if (is_right) pend_nx = P_RIGHT;
                    else if (is_cont)  pend_nx = P_DRIVE;
                    if (tmr_q == '0) begin
                        pend_d = P_NONE;
                        case (pend_nx)
                            P_LEFT: begin
                                state_d = TURN_L;
                                tmr_d   = TURN_LOAD;
                            end
                            P_RIGHT: begin
                                state_d = TURN_R;
                                tmr_d   = TURN_LOAD;
                            end
                            default: begin
                                state_d = DRIVE;
                                wdog_d  = WDOG_LOAD;
                            end
                        endcase
                    end else begin
                        tmr_d  = tmr_q - 1'b1;
                        pend_d = pend_nx;
                    end
                end
            end
            BRAKE: begin
                if (is_stop)           tmr_d   = BRAKE_LOAD;
                else if (tmr_q == '0)  state_d = IDLE;
                else                   tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating count of unrecognised codes, in any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               fault_cnt <= 8'd0;
        else if (is_bad && fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
    end

    assign state_o     = state_q;
    assign motor_en    = (state_q == DRIVE) || (state_q == TURN_L) || (state_q == TURN_R);
    assign steer_left  = (state_q == TURN_L);
    assign steer_right = (state_q == TURN_R);
    assign brake       = (state_q == IDLE) || (state_q == BRAKE);
    assign busy        = (state_q == TURN_L) || (state_q == TURN_R) || (state_q == BRAKE);
endmodule
